// File: rtl/temporal_encoder_n.sv
// Binary-to-temporal transmitter: a captured vector of binary times becomes edges or pulses
// on the y lines within one gamma cycle. A one-cycle FLUSH follows, which drives the downstream gamma reset.
module temporal_encoder_n #(
  parameter int NUM_INPUTS        = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int MODE              = 0,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                            clk,
  input  logic                            grst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0] in_values,
  input  logic [VAL_WIDTH-1:0]            in_sel,
  output logic [NUM_INPUTS:0]             y,
  output logic                            gamma_start,
  output logic                            gamma_rst,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  localparam int G  = GAMMA_CYCLE_WIDTH;
  localparam int KW = (G > 2) ? $clog2(G) : 1;
  localparam int NL = NUM_INPUTS + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Handshake: a load transfers on a clk edge where in_valid && in_ready.
  // in_ready is high in IDLE and FLUSH, and low in RUN. Requests made in RUN are ignored.
  state_t               r_state, w_state_nxt;
  logic [KW-1:0]        r_k, w_k_nxt;
  logic [NL*VAL_WIDTH-1:0] r_vals, w_vals_nxt;
  logic [NL-1:0]        r_y, w_y_nxt;
  logic                 r_start, r_rst, r_busy, r_in_ready;

  // Level of one line at gamma step k. An MSB-set value, or any value >= G, never fires.
  function automatic logic line_level(input logic [VAL_WIDTH-1:0] v, input logic [KW-1:0] k);
    logic [31:0] vv;
    logic [31:0] kk;
    logic        fin;
    vv  = 32'(v);
    kk  = 32'(k);
    fin = !v[VAL_WIDTH-1] && (vv < 32'(G));
    if (MODE == 0)      line_level = fin && (kk >= vv);
    else if (MODE == 1) line_level = !fin || (kk < vv);
    else if (MODE == 2) line_level = fin && (kk >= vv) && (kk < vv + 32'(PULSE_WIDTH));
    else                line_level = 1'b0;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_vals_nxt  = r_vals;
    w_y_nxt     = '0;
    case (r_state)
      // in_ready is high in both of these states, so in_valid alone means a transfer.
      S_IDLE, S_FLUSH: begin
        if (in_valid) begin
          w_state_nxt = S_RUN;
          w_k_nxt     = '0;
          w_vals_nxt  = {in_sel, in_values};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_k == KW'(G - 1)) begin
          w_state_nxt = S_FLUSH;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_RUN) begin
      for (int i = 0; i < NL; i++) begin
        w_y_nxt[i] = line_level(w_vals_nxt[i*VAL_WIDTH +: VAL_WIDTH], w_k_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_vals     <= '0;
      r_y        <= '0;
      r_start    <= 1'b0;
      r_rst      <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_vals     <= w_vals_nxt;
      r_y        <= w_y_nxt;
      r_start    <= (w_state_nxt == S_RUN) && (r_state != S_RUN);
      r_rst      <= (w_state_nxt == S_FLUSH);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_in_ready <= (w_state_nxt != S_RUN);
    end
  end

  assign y           = r_y;
  assign gamma_start = r_start;
  assign gamma_rst   = r_rst;
  assign busy        = r_busy;
  assign in_ready    = r_in_ready;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_temporal_encoder_n.sv
// Bench for temporal_encoder_n: three instances (rising, falling, pulse) share one stimulus stream,
// and every cycle of each instance is checked against a queue of expected output records.
module tb_temporal_encoder_n;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = 5;
  localparam int YW = N + 1;
  localparam int RW = YW + 4;

  // Record layout: {in_ready, gamma_start, gamma_rst, busy, y}
  localparam logic [RW-1:0] IDLE_REC  = {1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
  localparam logic [RW-1:0] FLUSH_REC = {1'b1, 1'b0, 1'b1, 1'b1, 5'b00000};

  logic              clk = 1'b0;
  logic              grst = 1'b1;
  logic              in_valid = 1'b0;
  logic [N*VW-1:0]   in_values = '0;
  logic [VW-1:0]     in_sel = '0;

  logic [2:0][YW-1:0] y_m;
  logic [2:0]         rdy_m, gs_m, gr_m, bz_m;
  logic [2:0][1:0]    st_m;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    temporal_encoder_n #(
      .NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .MODE(m), .VAL_WIDTH(VW)
    ) u_dut (
      .clk(clk), .grst(grst), .in_valid(in_valid), .in_ready(rdy_m[m]),
      .in_values(in_values), .in_sel(in_sel), .y(y_m[m]),
      .gamma_start(gs_m[m]), .gamma_rst(gr_m[m]), .busy(bz_m[m]), .dbg_state(st_m[m])
    );
  end

  always #5 clk = ~clk;

  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  logic [RW-1:0] exp_q2[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference waveform of one line, written straight from the mode definitions.
  function automatic logic model_level(input int mode, input logic [VW-1:0] v, input int k);
    int vi;
    bit fin;
    vi  = int'(v);
    fin = (v[VW-1] == 1'b0) && (vi < G);
    case (mode)
      0:       return fin && (k >= vi);
      1:       return !fin || (k < vi);
      default: return fin && (k >= vi) && (k < vi + PW);
    endcase
  endfunction

  function automatic logic [RW-1:0] run_rec(input int mode, input logic [N*VW-1:0] vals,
                                            input logic [VW-1:0] sel, input int k);
    logic [YW-1:0] yy;
    logic [VW-1:0] v;
    for (int j = 0; j < YW; j++) begin
      v     = (j == N) ? sel : vals[j*VW +: VW];
      yy[j] = model_level(mode, v, k);
    end
    return {1'b0, (k == 0), 1'b0, 1'b1, yy};
  endfunction

  task automatic push_gamma(input logic [N*VW-1:0] vals, input logic [VW-1:0] sel);
    for (int k = 0; k < G; k++) begin
      exp_q0.push_back(run_rec(0, vals, sel, k));
      exp_q1.push_back(run_rec(1, vals, sel, k));
      exp_q2.push_back(run_rec(2, vals, sel, k));
    end
    exp_q0.push_back(FLUSH_REC);
    exp_q1.push_back(FLUSH_REC);
    exp_q2.push_back(FLUSH_REC);
  endtask

  // Monitor on the falling edge: an empty queue means the DUT must be idle.
  bit            mon_en = 1'b0;
  int            k0 = 0;
  logic [YW-1:0] ylast0;
  logic [RW-1:0] e0, e1, e2;

  always @(negedge clk) begin
    if (mon_en) begin
      e0 = IDLE_REC;
      e1 = IDLE_REC;
      e2 = IDLE_REC;
      if (exp_q0.size() > 0) e0 = exp_q0.pop_front();
      if (exp_q1.size() > 0) e1 = exp_q1.pop_front();
      if (exp_q2.size() > 0) e2 = exp_q2.pop_front();
      chk("mode0_cycle", {rdy_m[0], gs_m[0], gr_m[0], bz_m[0], y_m[0]}, e0);
      chk("mode1_cycle", {rdy_m[1], gs_m[1], gr_m[1], bz_m[1], y_m[1]}, e1);
      chk("mode2_cycle", {rdy_m[2], gs_m[2], gr_m[2], bz_m[2], y_m[2]}, e2);
      if (gs_m[0]) k0 = 0;
      else         k0++;
      if (bz_m[0] && !gr_m[0] && k0 == G - 1) ylast0 = y_m[0];
    end
  end

  // Waits for in_ready, presents the load, and queues its gamma cycle at the transfer edge.
  task automatic load(input logic [N*VW-1:0] vals, input logic [VW-1:0] sel, input bit hold);
    int guard;
    guard = 0;
    while (rdy_m[0] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("load_ready", RW'(rdy_m[0]), RW'(1));
    in_valid  = 1'b1;
    in_values = vals;
    in_sel    = sel;
    @(posedge clk);
    push_gamma(vals, sel);
    #1;
    if (!hold) in_valid = 1'b0;
    in_values = N*VW'($urandom);
    in_sel    = VW'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((bz_m[0] !== 1'b0 || exp_q0.size() != 0) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("idle_reached", RW'(bz_m[0]), '0);
  endtask

  typedef struct {
    logic [N*VW-1:0] vals;
    logic [VW-1:0]   sel;
    logic [YW-1:0]   y_last_m0;
    bit              has_exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{vals: {5'd15, 5'd8, 5'd3, 5'd0},     sel: 5'd5,  y_last_m0: 5'b11111, has_exp: 1'b1};
    tbl[1] = '{vals: {5'h1F, 5'd20, 5'd2, 5'd12},   sel: 5'h10, y_last_m0: 5'b00011, has_exp: 1'b1};
    tbl[2] = '{vals: {5'd15, 5'h18, 5'd4, 5'd0},    sel: 5'd0,  y_last_m0: 5'b11011, has_exp: 1'b1};
    tbl[3] = '{vals: {5'd16, 5'd17, 5'd1, 5'd14},   sel: 5'd15, y_last_m0: 5'b10011, has_exp: 1'b1};
    for (int i = 4; i < 6; i++) begin
      for (int j = 0; j < N; j++) tbl[i].vals[j*VW +: VW] = VW'($urandom_range(0, 31));
      tbl[i].sel       = VW'($urandom_range(0, 31));
      tbl[i].y_last_m0 = '0;
      tbl[i].has_exp   = 1'b0;
    end

    // Clock/reset
    grst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    grst = 1'b0;
    for (int m = 0; m < 3; m++) begin
      chk("reset_outputs", {rdy_m[m], gs_m[m], gr_m[m], bz_m[m], y_m[m]}, IDLE_REC);
      chk("reset_state", RW'(st_m[m]), '0);
    end
    mon_en = 1'b1;

    // Table-driven single loads
    for (int i = 0; i < 6; i++) begin
      ylast0 = 'x;
      load(tbl[i].vals, tbl[i].sel, 1'b0);
      wait_idle();
      if (tbl[i].has_exp) chk("y_last_mode0", RW'(ylast0), RW'(tbl[i].y_last_m0));
    end

    // Back-to-back gamma cycles with in_valid held high, then dropped
    load(tbl[0].vals, tbl[0].sel, 1'b1);
    load(tbl[2].vals, tbl[2].sel, 1'b1);
    load(tbl[1].vals, tbl[1].sel, 1'b0);
    wait_idle();

    // Reset during RUN at k=7 aborts without a FLUSH cycle
    load(tbl[0].vals, tbl[0].sel, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    grst = 1'b1;
    @(posedge clk);
    #1;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    grst = 1'b0;
    for (int m = 0; m < 3; m++) begin
      chk("after_grst_outputs", {rdy_m[m], gs_m[m], gr_m[m], bz_m[m], y_m[m]}, IDLE_REC);
      chk("after_grst_state", RW'(st_m[m]), '0);
    end
    load(tbl[3].vals, tbl[3].sel, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
